obi_result_mailbox: RTL and testbench
=====================================

Name: obi_result_mailbox

Overview:
- OBI data-port slave on the core's data bus, downstream of cv32e40x_core_with_aes, in parallel with the firmware memory.
- Firmware stores the 128-bit AES encryption and decryption results as four 32-bit words each. The block assembles them into result_enc_o and result_dec_o, which drive the testbench interface.
- Flags each result valid once all four words have been fully written.
- Status is readable back over the bus.

Parameters:
- BASE_ADDR, 32'h0000_8000, byte address of the mailbox window; 64-byte aligned.
- RESP_LATENCY, 1, cycles from grant to rvalid; legal values 1 or 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_req_i  in  1  OBI request, asserted only when the external decoder selects this window
- data_gnt_o  out  1  OBI grant
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  read data
- data_err_o  out  1  error response, qualified by rvalid
- result_enc_o  out  128  assembled encryption result
- result_dec_o  out  128  assembled decryption result
- enc_valid_o  out  1  all four enc words captured
- dec_valid_o  out  1  all four dec words captured

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: all outputs 0, result registers 0, word masks 0, response pipeline empty. Reset overrides any in-flight transaction; no rvalid follows a request granted in the cycle reset is asserted.
- Grant: data_gnt_o = data_req_i combinationally, so one transaction is accepted per cycle.
- Responses: each accepted transaction produces exactly one rvalid RESP_LATENCY cycles later, in order. The response pipeline is a RESP_LATENCY-deep shift register of {valid, err, rdata}.
- Window offset: off = data_addr_i - BASE_ADDR, using bits [5:0]; the upper bits are not checked.
- Register map:
  - 0x00..0x0C: ENC word k at offset 4k maps to result_enc_o[32k+31:32k]. Read/write.
  - 0x10..0x1C: DEC word k maps to result_dec_o[32k+31:32k]. Read/write.
  - 0x20 STATUS: read-only; {30'b0, dec_valid, enc_valid}. A write returns err and has no effect.
  - 0x24 CTRL: write-only; reads return 0. A write with data_be_i[0]=1 acts as follows:
    - wdata bit0 = 1 clears enc_mask and enc_valid.
    - wdata bit1 = 1 clears dec_mask and dec_valid.
    - Result data is retained.
  - 0x28..0x3C: err; no state change; rdata = 0.
- Misalignment: data_addr_i[1:0] != 0 gives err with no state change.
- Writes: byte-lane merge; only lanes with be=1 update. be=4'b0000 is a legal no-op that returns okay.
- Word mask: the mask bit for word k is set only by a full-word write (be=4'hF). A partial write updates the data but leaves the mask bit unchanged.
- Valid flags: enc_valid_o = &enc_mask and dec_valid_o = &dec_mask, both registered. A flag rises the cycle after the granting cycle of the completing write. The update lands together with the data register.
- Restart: a full-word write to any ENC word while enc_valid_o=1 restarts capture. enc_mask becomes one-hot for that word and enc_valid_o drops on the next cycle. DEC behaves identically.
- Rewrite before complete: rewriting an already-set word while the mask is incomplete overwrites the data; the mask is unchanged.
- Reads: return the current register value sampled in the grant cycle. A read-after-write on back-to-back cycles sees the new data.
- Error responses: rdata = 0 whenever err = 1.
- Outputs result_*_o reflect the registers continuously; consumers qualify them with the *_valid_o flags.

Test Plan:
1. Reset, then full-word writes 0x11111111, 0x22222222, 0x33333333, 0x44444444 to offsets 0x00..0x0C → result_enc_o=128'h44444444_33333333_22222222_11111111. enc_valid_o=1 exactly 1 cycle after the 4th grant, and never before.
2. DEC word 2 written with be=4'b0011, data 0xAABBCCDD over 0 → word = 0x0000CCDD, dec_mask bit2 clear. Then words 0,1,3 full-written → dec_valid_o stays 0 until a full write of word 2.
3. With enc_valid=1: write ENC word 1 = 0xDEADBEEF → enc_valid_o falls next cycle; reading STATUS returns 0x0 (given dec_valid=0); the other three words are retained.
4. Write STATUS (0x20) → rvalid with err=1 and rdata=0. Read at 0x30 → err. Read at address BASE+0x02 → err. In all three cases, status and result registers are unchanged.
5. Back-to-back, no idle cycles: write CTRL 0x3, then read STATUS → read returns 0x0. rvalid is asserted in two consecutive cycles for RESP_LATENCY=1 and RESP_LATENCY=2, with responses in order.
6. Reset asserted for one cycle, in the cycle after a write grant, with RESP_LATENCY=2 → no rvalid appears afterwards; all outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/obi_result_mailbox.sv
// -----------------------------------------------------------------------------
// obi_result_mailbox
//
// OBI data-port slave that collects the 128-bit AES encryption and decryption
// results, which firmware stores as four 32-bit words each. Each word lands in
// its own register and the assembled results are driven out continuously. A
// per-result word mask records which words have been fully written. The
// matching valid flag rises once all four mask bits are set.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   data_req_i          request; the external decoder asserts it only inside
//                       this window
//   data_gnt_o          grant (always equals data_req_i)
//   data_addr_i         byte address; only the window offset bits [5:0]
//                       are decoded
//   data_we_i           write enable
//   data_be_i           byte enables
//   data_wdata_i        write data
//   data_rvalid_o       response valid, RESP_LATENCY cycles after the grant
//   data_rdata_o        read data (0 on error)
//   data_err_o          error response, qualified by data_rvalid_o
//   result_enc_o        assembled encryption result
//   result_dec_o        assembled decryption result
//   enc_valid_o         all four encryption words captured
//   dec_valid_o         all four decryption words captured
//
// Register map (byte offset from BASE_ADDR):
//   0x00..0x0C ENC word 0..3 (RW)      0x10..0x1C DEC word 0..3 (RW)
//   0x20 STATUS {dec_valid, enc_valid} (RO, a write errors)
//   0x24 CTRL (WO): bit0 clears the ENC mask, bit1 clears the DEC mask
//   0x28..0x3C and misaligned addresses: error, no state change
// -----------------------------------------------------------------------------
module obi_result_mailbox #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         data_req_i,
    output logic         data_gnt_o,
    input  logic [31:0]  data_addr_i,
    input  logic         data_we_i,
    input  logic [3:0]   data_be_i,
    input  logic [31:0]  data_wdata_i,
    output logic         data_rvalid_o,
    output logic [31:0]  data_rdata_o,
    output logic         data_err_o,
    output logic [127:0] result_enc_o,
    output logic [127:0] result_dec_o,
    output logic         enc_valid_o,
    output logic         dec_valid_o
);

    // Only 1 and 2 are legal latencies; anything else behaves as 1.
    localparam int unsigned LAT = (RESP_LATENCY == 2) ? 2 : 1;

    logic [5:0]        off_s;
    logic [1:0]        word_idx_s;
    logic [25:0]       unused_addr_s;

    logic [3:0][31:0]  enc_q, enc_d;
    logic [3:0][31:0]  dec_q, dec_d;
    logic [3:0]        enc_mask_q, enc_mask_d;
    logic [3:0]        dec_mask_q, dec_mask_d;
    logic              enc_valid_q, dec_valid_q;

    logic              rsp_err_s;
    logic [31:0]       rsp_rdata_s;

    logic [LAT-1:0]        pipe_valid_q;
    logic [LAT-1:0]        pipe_err_q;
    logic [LAT-1:0][31:0]  pipe_rdata_q;

    // Byte-lane merge: only lanes with their enable set take the new data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // The window is 64-byte aligned, so the offset is the low six address
    // bits minus the low six base bits; the upper address bits are ignored.
    assign off_s         = data_addr_i[5:0] - BASE_ADDR[5:0];
    assign word_idx_s    = off_s[3:2];
    assign unused_addr_s = data_addr_i[31:6];

    assign data_gnt_o = data_req_i;

    // Address decode, register next-state and response generation.
    always_comb begin
        enc_d       = enc_q;
        dec_d       = dec_q;
        enc_mask_d  = enc_mask_q;
        dec_mask_d  = dec_mask_q;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
        if (data_req_i) begin
            if (off_s[1:0] != 2'b00) begin
                rsp_err_s = 1'b1;
            end else begin
                case (off_s[5:4])
                    2'b00: begin
                        if (data_we_i) begin
                            enc_d[word_idx_s] = merge_bytes(enc_q[word_idx_s], data_wdata_i, data_be_i);
                            // A full-word write into a complete set restarts capture.
                            if (data_be_i == 4'hF) begin
                                if (enc_valid_q) begin
                                    enc_mask_d = 4'b0001 << word_idx_s;
                                end else begin
                                    enc_mask_d = enc_mask_q | (4'b0001 << word_idx_s);
                                end
                            end else begin
                                enc_mask_d = enc_mask_q;
                            end
                        end else begin
                            rsp_rdata_s = enc_q[word_idx_s];
                        end
                    end
                    2'b01: begin
                        if (data_we_i) begin
                            dec_d[word_idx_s] = merge_bytes(dec_q[word_idx_s], data_wdata_i, data_be_i);
                            if (data_be_i == 4'hF) begin
                                if (dec_valid_q) begin
                                    dec_mask_d = 4'b0001 << word_idx_s;
                                end else begin
                                    dec_mask_d = dec_mask_q | (4'b0001 << word_idx_s);
                                end
                            end else begin
                                dec_mask_d = dec_mask_q;
                            end
                        end else begin
                            rsp_rdata_s = dec_q[word_idx_s];
                        end
                    end
                    2'b10: begin
                        case (off_s[3:2])
                            2'b00: begin
                                if (data_we_i) begin
                                    rsp_err_s = 1'b1;
                                end else begin
                                    rsp_rdata_s = {30'd0, dec_valid_q, enc_valid_q};
                                end
                            end
                            2'b01: begin
                                // CTRL clears masks only; captured data is kept.
                                if (data_we_i && data_be_i[0]) begin
                                    if (data_wdata_i[0]) begin
                                        enc_mask_d = 4'b0000;
                                    end else begin
                                        enc_mask_d = enc_mask_q;
                                    end
                                    if (data_wdata_i[1]) begin
                                        dec_mask_d = 4'b0000;
                                    end else begin
                                        dec_mask_d = dec_mask_q;
                                    end
                                end else begin
                                    rsp_rdata_s = 32'h0000_0000;
                                end
                            end
                            default: rsp_err_s = 1'b1;
                        endcase
                    end
                    default: rsp_err_s = 1'b1;
                endcase
            end
        end else begin
            rsp_err_s = 1'b0;
        end
    end

    // Result, mask and valid-flag registers; the flags update with the data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enc_q       <= '0;
            dec_q       <= '0;
            enc_mask_q  <= 4'b0000;
            dec_mask_q  <= 4'b0000;
            enc_valid_q <= 1'b0;
            dec_valid_q <= 1'b0;
        end else begin
            enc_q       <= enc_d;
            dec_q       <= dec_d;
            enc_mask_q  <= enc_mask_d;
            dec_mask_q  <= dec_mask_d;
            enc_valid_q <= &enc_mask_d;
            dec_valid_q <= &dec_mask_d;
        end
    end

    // Response shift register; reset drops anything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            pipe_rdata_q <= '0;
        end else begin
            pipe_valid_q[0] <= data_req_i;
            pipe_err_q[0]   <= rsp_err_s;
            pipe_rdata_q[0] <= rsp_rdata_s;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_rdata_q[i] <= pipe_rdata_q[i-1];
            end
        end
    end

    assign data_rvalid_o = pipe_valid_q[LAT-1];
    assign data_err_o    = pipe_err_q[LAT-1];
    assign data_rdata_o  = pipe_rdata_q[LAT-1];
    assign result_enc_o  = enc_q;
    assign result_dec_o  = dec_q;
    assign enc_valid_o   = enc_valid_q;
    assign dec_valid_o   = dec_valid_q;

endmodule

// File: tb/tb_obi_result_mailbox.sv
module tb_obi_result_mailbox;

    localparam logic [31:0] BASE = 32'h0000_8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic         gnt1, rv1, err1, ev1, dv1;
    logic [31:0]  rd1;
    logic [127:0] renc1, rdec1;
    logic         gnt2, rv2, err2, ev2, dv2;
    logic [31:0]  rd2;
    logic [127:0] renc2, rdec2;

    obi_result_mailbox #(.BASE_ADDR(BASE), .RESP_LATENCY(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt1),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv1), .data_rdata_o(rd1), .data_err_o(err1),
        .result_enc_o(renc1), .result_dec_o(rdec1), .enc_valid_o(ev1), .dec_valid_o(dv1)
    );

    obi_result_mailbox #(.BASE_ADDR(BASE), .RESP_LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt2),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rv2), .data_rdata_o(rd2), .data_err_o(err2),
        .result_enc_o(renc2), .result_dec_o(rdec2), .enc_valid_o(ev2), .dec_valid_o(dv2)
    );

    typedef struct packed {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t q1[$];
    rsp_t q2[$];
    rsp_t e1, e2;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    logic [31:0] m_enc [4];
    logic [31:0] m_dec [4];
    logic [3:0]  m_emask, m_dmask;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response monitors: pop expected response, check arrival cycle and payload.
    always @(negedge clk) begin
        if (rv1 === 1'b1) begin
            check("rv1_expected", 128'(q1.size() != 0), 128'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("rv1_cycle", 128'(cyc), 128'(e1.due));
                check("rv1_err", 128'(err1), 128'(e1.err));
                check("rv1_rdata", 128'(rd1), 128'(e1.rdata));
            end
        end
    end

    always @(negedge clk) begin
        if (rv2 === 1'b1) begin
            check("rv2_expected", 128'(q2.size() != 0), 128'd1);
            if (q2.size() != 0) begin
                e2 = q2.pop_front();
                check("rv2_cycle", 128'(cyc), 128'(e2.due));
                check("rv2_err", 128'(err2), 128'(e2.err));
                check("rv2_rdata", 128'(rd2), 128'(e2.rdata));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_enc[i] = 32'h0;
            m_dec[i] = 32'h0;
        end
        m_emask = 4'h0;
        m_dmask = 4'h0;
    endtask

    // One bus transaction: update the model, push the expected response,
    // hold the request for one grant cycle. Returns 1 time unit after that edge.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [5:0]  off;
        logic        e;
        logic [31:0] r;
        int          k;
        rsp_t        x;
        off = 6'(a - BASE);
        e   = 1'b0;
        r   = 32'h0;
        k   = int'(off[3:2]);
        if (off[1:0] != 2'b00) begin
            e = 1'b1;
        end else if (off < 6'h10) begin
            if (w) begin
                for (int i = 0; i < 4; i++) if (b[i]) m_enc[k][8*i +: 8] = d[8*i +: 8];
                if (b == 4'hF) m_emask = (m_emask == 4'hF) ? (4'b0001 << k) : (m_emask | (4'b0001 << k));
            end else r = m_enc[k];
        end else if (off < 6'h20) begin
            if (w) begin
                for (int i = 0; i < 4; i++) if (b[i]) m_dec[k][8*i +: 8] = d[8*i +: 8];
                if (b == 4'hF) m_dmask = (m_dmask == 4'hF) ? (4'b0001 << k) : (m_dmask | (4'b0001 << k));
            end else r = m_dec[k];
        end else if (off == 6'h20) begin
            if (w) e = 1'b1;
            else   r = {30'd0, m_dmask == 4'hF, m_emask == 4'hF};
        end else if (off == 6'h24) begin
            if (w && b[0]) begin
                if (d[0]) m_emask = 4'h0;
                if (d[1]) m_dmask = 4'h0;
            end
        end else begin
            e = 1'b1;
        end
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        x.err = e; x.rdata = r;
        x.due = cyc + 1; q1.push_back(x);
        x.due = cyc + 2; q2.push_back(x);
        #1;
        check("gnt1", 128'(gnt1), 128'd1);
        check("gnt2", 128'(gnt2), 128'd1);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_enc1"}, renc1, {m_enc[3], m_enc[2], m_enc[1], m_enc[0]});
        check({tag, "_enc2"}, renc2, {m_enc[3], m_enc[2], m_enc[1], m_enc[0]});
        check({tag, "_dec1"}, rdec1, {m_dec[3], m_dec[2], m_dec[1], m_dec[0]});
        check({tag, "_dec2"}, rdec2, {m_dec[3], m_dec[2], m_dec[1], m_dec[0]});
        check({tag, "_ev1"}, 128'(ev1), 128'(m_emask == 4'hF));
        check({tag, "_ev2"}, 128'(ev2), 128'(m_emask == 4'hF));
        check({tag, "_dv1"}, 128'(dv1), 128'(m_dmask == 4'hF));
        check({tag, "_dv2"}, 128'(dv2), 128'(m_dmask == 4'hF));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rv1"}, 128'(rv1), 128'd0);
        check({tag, "_rv2"}, 128'(rv2), 128'd0);
        check({tag, "_err1"}, 128'(err1), 128'd0);
        check({tag, "_err2"}, 128'(err2), 128'd0);
        check({tag, "_rd1"}, 128'(rd1), 128'd0);
        check({tag, "_rd2"}, 128'(rd2), 128'd0);
        check({tag, "_gnt1"}, 128'(gnt1), 128'd0);
        check({tag, "_gnt2"}, 128'(gnt2), 128'd0);
        check_state(tag);
        check({tag, "_enc_zero"}, renc1, 128'd0);
        check({tag, "_ev_zero"}, 128'(ev1 | dv1 | ev2 | dv2), 128'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; be = 4'h0; wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // 1: four full ENC writes; valid only after the fourth grant.
        bus(1'b1, BASE + 32'h00, 4'hF, 32'h1111_1111);
        check("t1_ev_w0", 128'(ev1), 128'd0);
        bus(1'b1, BASE + 32'h04, 4'hF, 32'h2222_2222);
        check("t1_ev_w1", 128'(ev2), 128'd0);
        bus(1'b1, BASE + 32'h08, 4'hF, 32'h3333_3333);
        check("t1_ev1_w2", 128'(ev1), 128'd0);
        check("t1_ev2_w2", 128'(ev2), 128'd0);
        bus(1'b1, BASE + 32'h0C, 4'hF, 32'h4444_4444);
        check("t1_ev1", 128'(ev1), 128'd1);
        check("t1_ev2", 128'(ev2), 128'd1);
        check("t1_enc", renc1, 128'h44444444_33333333_22222222_11111111);
        bus(1'b0, BASE + 32'h08, 4'hF, 32'h0);
        bus(1'b0, BASE + 32'h20, 4'hF, 32'h0);
        check_state("t1");

        // 3: restart while valid; STATUS reads 0; other words retained.
        bus(1'b1, BASE + 32'h04, 4'hF, 32'hDEAD_BEEF);
        check("t3_ev_drop", 128'(ev1), 128'd0);
        bus(1'b0, BASE + 32'h20, 4'hF, 32'h0);
        check("t3_enc", renc2, 128'h44444444_33333333_DEADBEEF_11111111);
        // Rewrite before complete keeps the mask; then complete the set.
        bus(1'b1, BASE + 32'h04, 4'hF, 32'h1234_5678);
        bus(1'b1, BASE + 32'h00, 4'hF, 32'hA0A0_A0A0);
        bus(1'b1, BASE + 32'h08, 4'hF, 32'hB0B0_B0B0);
        check("t3_ev_incomplete", 128'(ev1), 128'd0);
        bus(1'b1, BASE + 32'h0C, 4'hF, 32'hC0C0_C0C0);
        check("t3_ev_again", 128'(ev1), 128'd1);
        check_state("t3");

        // 2: partial DEC write sets data but not the mask bit.
        bus(1'b1, BASE + 32'h18, 4'b0011, 32'hAABB_CCDD);
        check("t2_partial", 128'(rdec1[95:64]), 128'h0000_CCDD);
        bus(1'b1, BASE + 32'h10, 4'hF, 32'h5050_5050);
        bus(1'b1, BASE + 32'h14, 4'hF, 32'h6060_6060);
        bus(1'b1, BASE + 32'h1C, 4'hF, 32'h7070_7070);
        check("t2_dv_held", 128'(dv1), 128'd0);
        bus(1'b0, BASE + 32'h18, 4'hF, 32'h0);
        bus(1'b1, BASE + 32'h18, 4'hF, 32'h8080_8080);
        check("t2_dv1", 128'(dv1), 128'd1);
        check("t2_dv2", 128'(dv2), 128'd1);
        bus(1'b0, BASE + 32'h20, 4'hF, 32'h0);
        // be=0 is an okay no-op.
        bus(1'b1, BASE + 32'h00, 4'h0, 32'hFFFF_FFFF);
        check_state("t2");

        // 4: error cases leave everything unchanged.
        bus(1'b1, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        bus(1'b0, BASE + 32'h30, 4'hF, 32'h0);
        bus(1'b0, BASE + 32'h02, 4'hF, 32'h0);
        bus(1'b1, BASE + 32'h05, 4'hF, 32'h0);
        bus(1'b1, BASE + 32'h3C, 4'hF, 32'hFFFF_FFFF);
        check("t4_ev", 128'(ev1 & dv1 & ev2 & dv2), 128'd1);
        check_state("t4");

        // 5: back-to-back CTRL clear then STATUS read; data retained.
        bus(1'b1, BASE + 32'h24, 4'h1, 32'h0000_0003);
        bus(1'b0, BASE + 32'h20, 4'hF, 32'h0);
        bus(1'b0, BASE + 32'h24, 4'hF, 32'h0);
        bus(1'b0, BASE + 32'h0C, 4'hF, 32'h0);
        check("t5_dec_kept", rdec2, 128'h70707070_80808080_60606060_50505050);
        check_state("t5");

        // 6: reset one cycle after a write grant, with a request in the reset cycle.
        bus(1'b1, BASE + 32'h00, 4'hF, 32'hCAFE_F00D);
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = BASE + 32'h20; be = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0;
        q2.delete();
        model_reset();
        check_all_zero("t6");
        repeat (4) @(posedge clk);
        #1;
        check("t6_rv_none", 128'(rv1 | rv2), 128'd0);
        check("end_q1_empty", 128'(q1.size()), 128'd0);
        check("end_q2_empty", 128'(q2.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
